// File: rtl/fpu_cmp_pipe.sv
// fpu_cmp_pipe: two-stage pipelined compare / min-max unit for recoded floats.
//
// Stage 1 holds the accepted operation (op, a, b). Stage 2 is the output
// register holding the computed result and its exception flags. A sticky
// accrued-flags register ORs in the flags of every result the consumer takes.
//
// Recoded word layout (W = expSize+sigSize+1 bits):
//   [W-1]           sign
//   [W-2:sigSize-1] exponent (expSize+1 bits)
//   [sigSize-2:0]   significand without hidden bit
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operation handshake; in_op selects FEQ/FLT/FLE/FMIN/FMAX
//   in_a, in_b          recoded operands
//   kill                synchronous flush of both pipeline stages
//   out_valid/out_ready result handshake
//   out_data            compare bit in bit 0, or the selected min/max value
//   out_flags           {NV,DZ,OF,UF,NX} for the current result
//   flags_clr           clear accrued flags
//   flags_acc           sticky OR of out_flags over completed transfers
//
// Build option: define FPU_CMP_MINMAX_EN to build FMIN/FMAX. Without it those
// opcodes behave as reserved (zero result, no flags).

module fpu_cmp_pipe #(
  parameter int expSize = 8,
  parameter int sigSize = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_op,
  input  logic [expSize+sigSize:0]     in_a,
  input  logic [expSize+sigSize:0]     in_b,
  input  logic                         kill,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [expSize+sigSize:0]     out_data,
  output logic [4:0]                   out_flags,
  input  logic                         flags_clr,
  output logic [4:0]                   flags_acc
);

  localparam int W = expSize + sigSize + 1;
  localparam int S = expSize + sigSize;

  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
`ifdef FPU_CMP_MINMAX_EN
  localparam logic [2:0] OP_FMIN = 3'b011;
  localparam logic [2:0] OP_FMAX = 3'b100;
  localparam logic [W-1:0] CANON_NAN = (W'(3'b111) << (S - 3)) | (W'(1) << (sigSize - 2));
`endif

  logic         s1Valid;
  logic [2:0]   s1Op;
  logic [W-1:0] s1A, s1B;
  logic         s2Valid;
  logic [W-1:0] s2Data;
  logic [4:0]   s2Flags;
  logic [4:0]   accFlags;

  logic s1Adv, xfer;

  // s1 may move into s2 when s2 is empty or being drained this cycle.
  assign s1Adv    = ~s2Valid | out_ready;
  assign in_ready = (~s1Valid | s1Adv) & ~kill;
  // A result drained during a kill is flushed, so it does not accrue flags.
  assign xfer     = s2Valid & out_ready & ~kill;

  // Operand classification
  logic aNaN, bNaN, aSnan, bSnan, aZero, bZero, aSign, bSign;
  logic [S-1:0] aMag, bMag;
  logic ordered, bothZero, anyNaN, anySnan, eqOrd, ltOrd;

  assign aSign    = s1A[S];
  assign bSign    = s1B[S];
  assign aMag     = s1A[S-1:0];
  assign bMag     = s1B[S-1:0];
  assign aNaN     = (s1A[S-1:S-3] == 3'b111);
  assign bNaN     = (s1B[S-1:S-3] == 3'b111);
  assign aSnan    = aNaN & ~s1A[sigSize-2];
  assign bSnan    = bNaN & ~s1B[sigSize-2];
  assign aZero    = (s1A[S-1:S-3] == 3'b000);
  assign bZero    = (s1B[S-1:S-3] == 3'b000);
  assign anyNaN   = aNaN | bNaN;
  assign anySnan  = aSnan | bSnan;
  assign ordered  = ~anyNaN;
  assign bothZero = aZero & bZero;
  assign eqOrd    = ordered & (bothZero | (s1A == s1B));

  // a < b for ordered operands; zeros of either sign are equal here.
  always_comb begin
    ltOrd = 1'b0;
    if (bothZero)            ltOrd = 1'b0;
    else if (aSign != bSign) ltOrd = aSign;
    else if (!aSign)         ltOrd = (aMag < bMag);
    else                     ltOrd = (aMag > bMag);
  end

`ifdef FPU_CMP_MINMAX_EN
  // Selection ordering: same as compare ordering except -0 < +0.
  logic gtOrd, aLtSel, bLtSel;
  always_comb begin
    gtOrd = 1'b0;
    if (bothZero)            gtOrd = 1'b0;
    else if (aSign != bSign) gtOrd = bSign;
    else if (!aSign)         gtOrd = (aMag > bMag);
    else                     gtOrd = (aMag < bMag);
  end
  assign aLtSel = bothZero ? (aSign & ~bSign) : ltOrd;
  assign bLtSel = bothZero ? (bSign & ~aSign) : gtOrd;
`endif

  logic [W-1:0] resData;
  logic [4:0]   resFlags;

  always_comb begin
    resData  = '0;
    resFlags = '0;
    case (s1Op)
      OP_FEQ: begin
        resData[0]  = eqOrd;
        resFlags[4] = anySnan;
      end
      OP_FLT: begin
        resData[0]  = ordered & ltOrd;
        resFlags[4] = anyNaN;
      end
      OP_FLE: begin
        resData[0]  = ordered & (ltOrd | eqOrd);
        resFlags[4] = anyNaN;
      end
`ifdef FPU_CMP_MINMAX_EN
      OP_FMIN, OP_FMAX: begin
        resFlags[4] = anySnan;
        if (aNaN && bNaN)       resData = CANON_NAN;
        else if (aNaN)          resData = s1B;
        else if (bNaN)          resData = s1A;
        else if (s1Op == OP_FMIN) resData = bLtSel ? s1B : s1A;
        else                    resData = aLtSel ? s1B : s1A;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid  <= 1'b0;
      s1Op     <= '0;
      s1A      <= '0;
      s1B      <= '0;
      s2Valid  <= 1'b0;
      s2Data   <= '0;
      s2Flags  <= '0;
      accFlags <= '0;
    end else begin
      if (kill) begin
        s1Valid <= 1'b0;
        s2Valid <= 1'b0;
      end else begin
        if (s1Adv) begin
          s2Valid <= s1Valid;
          if (s1Valid) begin
            s2Data  <= resData;
            s2Flags <= resFlags;
          end
        end
        if (in_valid && in_ready) begin
          s1Valid <= 1'b1;
          s1Op    <= in_op;
          s1A     <= in_a;
          s1B     <= in_b;
        end else if (s1Adv) begin
          s1Valid <= 1'b0;
        end
      end
      if (flags_clr)  accFlags <= xfer ? s2Flags : 5'b0;
      else if (xfer)  accFlags <= accFlags | s2Flags;
    end
  end

  assign out_valid = s2Valid;
  assign out_data  = s2Data;
  assign out_flags = s2Flags;
  assign flags_acc = accFlags;

endmodule

// File: doc/fpu_cmp_pipe.md
Name: fpu_cmp_pipe

Overview:
- Two-stage pipelined compare/min-max execution unit for recoded floats (expSize+sigSize+1 bits).
- Sits downstream of the operand-recode stage and upstream of integer/FP writeback.
- Produces FEQ/FLT/FLE boolean results, or FMIN/FMAX recoded results, with IEEE exception flags.
- Valid/ready handshake on both sides; keeps a sticky accrued-flags register.

Parameters:
- expSize, 8, exponent width of the standard format (recoded exponent is expSize+1).
- sigSize, 24, significand width including hidden bit; recoded word is expSize+sigSize+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the operation this cycle.
- in_op  in  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others reserved.
- in_a, in_b  in  expSize+sigSize+1  recoded operands.
- kill  in  1  synchronous flush of all in-flight ops.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  expSize+sigSize+1  compare result in bit 0 (upper bits 0), or the min/max value.
- out_flags  out  5  {NV,DZ,OF,UF,NX} for this result.
- flags_clr  in  1  clear accrued flags.
- flags_acc  out  5  sticky OR of out_flags over all transfers.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_flags=0, flags_acc=0. Reset mid-operation discards all ops.
- Stage 1 registers op/a/b on in_valid&in_ready. Stage 2 registers the computed result.
- Latency: 2 cycles from accept to out_valid when unstalled. Throughput 1/cycle.
- in_ready = ~s1_valid | s1 advances. s1 advances when ~s2_valid | (out_valid&out_ready). No combinational path from in_valid to in_ready.
- While out_valid&~out_ready, out_data and out_flags hold stable.
- kill: next cycle s1_valid=0 and s2_valid=0. An op offered in the same cycle is not accepted (in_ready=0 while kill). flags_acc is not updated by killed ops.
- Classification, per operand with size = expSize+sigSize:
  - NaN if exp[size-1:size-3]==3'b111.
  - sNaN if NaN & sig MSB (bit sigSize-2)==0.
  - zero if exp[size-1:size-3]==3'b000.
  - +0 and -0 compare equal.
- Magnitude ordering: {exp,sig} unsigned; sign applied as IEEE totalOrder, excluding NaN.
- FEQ: 1 if ordered & equal. NV only if either operand is sNaN.
- FLT/FLE: result 0 if either operand is NaN. NV if either operand is any NaN (signaling compare).
- FMIN/FMAX:
  - Both NaN: canonical NaN (sign 0, exp top 3 bits 111, sig MSB 1, rest 0).
  - One NaN: return the other operand.
  - -0 is less than +0 for selection.
  - NV if either operand is sNaN.
- Reserved op: out_data=0, out_flags=0.
- DZ/OF/UF/NX always 0.
- flags_acc updates on out_valid&out_ready: acc |= out_flags.
- flags_clr alone: acc=0. flags_clr together with a transfer: acc=out_flags of that transfer.

Optional Feature:
- FPU_CMP_MINMAX_EN.
- Defined: FMIN/FMAX are implemented as above.
- Undefined: ops 011/100 behave as reserved (out_data=0, no flags) and the min/max datapath muxes are not built.

Test Plan:
- f32, FLT: a=0x0_8000_0000 (1.0), b=0x0_8080_0000 (2.0) -> out_data=1, flags=0, out_valid exactly 2 cycles after accept.
- FEQ: a=0x0_0000_0000 (+0), b=0x1_0000_0000 (-0) -> out_data=1. FLT on the same operands -> 0.
- FEQ: a=0x0_E040_0000 (qNaN), b=1.0 -> 0, flags=5'h00. FLE with the same operands -> 0, flags=5'h10. FEQ with a=0x0_E000_0001 (sNaN) -> 0, flags=5'h10.
- FMIN: a=qNaN, b=0x1_8000_0000 (-1.0) -> 0x1_8000_0000. FMAX with a=sNaN, b=qNaN -> 0x0_E040_0000, flags=5'h10 (MINMAX_EN defined).
- Backpressure: out_ready=0 for 5 cycles while 3 ops are issued back-to-back -> only 2 accepted, out_data stable; on release, results return in order with no loss.
- Flags/kill: invalid op completes -> flags_acc=5'h10. flags_clr together with a clean transfer -> 0. kill with 2 ops in flight -> out_valid=0 next cycle, flags_acc unchanged. rst_n pulse mid-stream -> all outputs 0 immediately.
